// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined two's-complement adder/subtractor for the FPU mantissa path.
// The carry chain is cut into STAGES segments of SEG = ceil(WIDTH/STAGES) bits. Each stage
// adds its own segment using the carry registered by the previous stage. Operand bits for
// later segments travel along in the same stage registers until their stage is reached.
// Every stage has a valid bit. A stage reloads whenever it is empty or its contents move
// forward, so bubbles close up and the pipeline only stops when it is completely full.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  input handshake for A, B, aos (aos: 0 = A+B, 1 = A-B)
//   out_valid / out_ready output handshake for S, Co, Ov, Z
//   S   sum/difference modulo 2^WIDTH     Co  carry out of the MSB (sub: 1 = no borrow)
//   Ov  signed overflow                   Z   S == 0
module add_sub_pipe #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             aos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ov,
    output logic             Z
);

    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;
    localparam int L   = STAGES - 1;

    // One stage's payload. a/bx carry the operands (bx already conditioned for subtract),
    // s holds the bits resolved so far and c is the carry into the next segment.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] s;
        logic             c;
    } stg_t;

    stg_t              stg0;
    stg_t              stg_d [STAGES];
    stg_t              stg_q [STAGES];
    logic [STAGES-1:0] vld;
    logic [STAGES:0]   vld_pipe;   // bit 0 = incoming valid, bit k+1 = stage k valid
    logic [STAGES-1:0] ld;
    logic              ld_n;
    logic              ov_d, z_d, ov_q, z_q;

    function automatic int seg_hi(input int k);
        return ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG - 1 : WIDTH - 1;
    endfunction

    // Ripple-add bits [lo, hi] of the payload. If lo > hi the segment is empty (this happens
    // for some WIDTH/STAGES pairs) and the carry is simply passed on.
    function automatic stg_t seg_add(input stg_t src, input int lo, input int hi);
        stg_t r;
        logic cy;
        r  = src;
        cy = src.c;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= lo && i <= hi) begin
                r.s[i] = src.a[i] ^ src.bx[i] ^ cy;
                cy     = (src.a[i] & src.bx[i]) | (cy & (src.a[i] ^ src.bx[i]));
            end
        end
        r.c = cy;
        return r;
    endfunction

    assign vld_pipe = {vld, in_valid};

    // Load enables run from the output back to the input: stage k may load if it is empty
    // or stage k+1 is loading (the last stage frees up when out_ready is high).
    always_comb begin
        ld   = '0;
        ld_n = out_ready;
        for (int k = L; k >= 0; k--) begin
            ld[k] = !vld[k] || ld_n;
            ld_n  = ld[k];
        end
    end

    always_comb begin
        stg0.a  = A;
        stg0.bx = B ^ {WIDTH{aos}};
        stg0.s  = '0;
        stg0.c  = aos;
        stg_d[0] = seg_add(stg0, 0, seg_hi(0));
        for (int k = 1; k < STAGES; k++)
            stg_d[k] = seg_add(stg_q[k-1], k * SEG, seg_hi(k));
        // Flags come from the full result entering the last stage, so they register with it.
        z_d  = (stg_d[L].s == '0);
        ov_d = (stg_d[L].a[WIDTH-1] == stg_d[L].bx[WIDTH-1]) &&
               (stg_d[L].s[WIDTH-1] != stg_d[L].a[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= '0;
            ov_q <= 1'b0;
            z_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld[k] <= vld_pipe[k];
                    // Payload only moves with a valid op, keeping outputs quiet and defined.
                    if (vld_pipe[k]) stg_q[k] <= stg_d[k];
                end
            end
            if (ld[L] && vld_pipe[L]) begin
                ov_q <= ov_d;
                z_q  <= z_d;
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld[L];
    assign S         = stg_q[L].s;
    assign Co        = stg_q[L].c;
    assign Ov        = ov_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: three instances (24/3, 24/1, 8/8) share one stimulus stream.
// Each instance has its own scoreboard queue filled from an arithmetic model on every accept.
module tb_add_sub_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        aos = 1'b0;
    logic [23:0] A = '0, B = '0;

    logic        ir [3];
    logic        vo [3];
    logic        co [3];
    logic        ovf[3];
    logic        zf [3];
    logic [23:0] s3, s1;
    logic [7:0]  s8;

    localparam int WD [3] = '{24, 24, 8};
    localparam int ST [3] = '{3, 1, 8};

    add_sub_pipe #(.WIDTH(24), .STAGES(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .A(A), .B(B), .aos(aos),
        .out_valid(vo[0]), .out_ready(out_ready), .S(s3), .Co(co[0]), .Ov(ovf[0]), .Z(zf[0]));
    add_sub_pipe #(.WIDTH(24), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .A(A), .B(B), .aos(aos),
        .out_valid(vo[1]), .out_ready(out_ready), .S(s1), .Co(co[1]), .Ov(ovf[1]), .Z(zf[1]));
    add_sub_pipe #(.WIDTH(8), .STAGES(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .A(A[7:0]), .B(B[7:0]),
        .aos(aos), .out_valid(vo[2]), .out_ready(out_ready), .S(s8), .Co(co[2]), .Ov(ovf[2]),
        .Z(zf[2]));

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    exp_t q[3][$];
    int   checks = 0;
    int   errors = 0;

    // Plain integer arithmetic: unsigned result/borrow and signed range test.
    function automatic exp_t model(input int w, input longint unsigned a_in,
                                   input longint unsigned b_in, input bit sub);
        exp_t            e;
        longint unsigned m, a, b;
        longint          half, sa, sb, sr;
        m    = (64'd1 << w) - 1;
        a    = a_in & m;
        b    = b_in & m;
        e.s  = 32'(sub ? (a - b) & m : (a + b) & m);
        e.co = sub ? (a >= b) : (((a + b) >> w) != 0);
        half = 64'sd1 <<< (w - 1);
        sa   = (a >= longint'(half)) ? longint'(a) - 2 * half : longint'(a);
        sb   = (b >= longint'(half)) ? longint'(b) - 2 * half : longint'(b);
        sr   = sub ? sa - sb : sa + sb;
        e.ov = (sr < -half) || (sr >= half);
        e.z  = (e.s == 0);
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Compare process: one pass per DUT each cycle, away from the active edge.
    bit   held[3];
    exp_t hv[3];
    always @(negedge clk) begin
        exp_t cur, e;
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                q[d].delete();
                held[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                cur.s  = (d == 0) ? 32'(s3) : (d == 1) ? 32'(s1) : 32'(s8);
                cur.co = co[d];
                cur.ov = ovf[d];
                cur.z  = zf[d];
                // Occupancy equals ops accepted but not yet delivered.
                cmp($sformatf("in_ready[%0d]", d), 64'(ir[d]),
                    64'((q[d].size() < ST[d]) || out_ready));
                if (held[d]) begin
                    cmp($sformatf("hold_valid[%0d]", d), 64'(vo[d]), 64'd1);
                    cmp($sformatf("hold_data[%0d]", d), {cur.s, cur.co, cur.ov, cur.z},
                        {hv[d].s, hv[d].co, hv[d].ov, hv[d].z});
                end
                if (q[d].size() == 0) begin
                    cmp($sformatf("idle_out_valid[%0d]", d), 64'(vo[d]), 64'd0);
                end else if (vo[d] && out_ready) begin
                    e = q[d].pop_front();
                    cmp($sformatf("S[%0d]", d), 64'(cur.s), 64'(e.s));
                    cmp($sformatf("Co[%0d]", d), 64'(cur.co), 64'(e.co));
                    cmp($sformatf("Ov[%0d]", d), 64'(cur.ov), 64'(e.ov));
                    cmp($sformatf("Z[%0d]", d), 64'(cur.z), 64'(e.z));
                end
                held[d] = vo[d] && !out_ready;
                hv[d]   = cur;
                if (in_valid && ir[d]) q[d].push_back(model(WD[d], 64'(A), 64'(B), aos));
            end
        end
    end

    logic [7:0] l8s;
    logic       l8co, l8z;

    // One op into empty pipelines; latency counted in edges including the accept edge.
    task automatic directed(input logic [23:0] a, input logic [23:0] b, input logic sub,
                            input logic [23:0] es, input logic eco, input logic eov,
                            input logic ez);
        int          lat[3];
        logic [23:0] gs;
        logic        gco, gov, gz;
        lat = '{0, 0, 0};
        gs = 'x; gco = 1'bx; gov = 1'bx; gz = 1'bx;
        A = a; B = b; aos = sub; in_valid = 1'b1; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            for (int d = 0; d < 3; d++) begin
                if (lat[d] == 0 && vo[d]) begin
                    lat[d] = c;
                    if (d == 0) begin gs = s3; gco = co[0]; gov = ovf[0]; gz = zf[0]; end
                    if (d == 2) begin l8s = s8; l8co = co[2]; l8z = zf[2]; end
                end
            end
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
            step;
        end
        cmp("latency_s3", 64'(lat[0]), 64'd3);
        cmp("latency_s1", 64'(lat[1]), 64'd1);
        cmp("latency_s8", 64'(lat[2]), 64'd8);
        cmp("dir_S", 64'(gs), 64'(es));
        cmp("dir_Co", 64'(gco), 64'(eco));
        cmp("dir_Ov", 64'(gov), 64'(eov));
        cmp("dir_Z", 64'(gz), 64'(ez));
        step;
    endtask

    task automatic drain;
        for (int c = 0; c < 40 && (q[0].size() + q[1].size() + q[2].size()) != 0; c++) step;
        cmp("drain_empty", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, cyc;
        bit  acc;
        exp_t m;

        // Reset, with in_valid asserted to show it is ignored.
        #1 rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_out_valid", 64'(vo[0]), 64'd0);
        cmp("rst_S", 64'(s3), 64'd0);
        cmp("rst_Co", 64'(co[0]), 64'd0);
        cmp("rst_Ov", 64'(ovf[0]), 64'd0);
        cmp("rst_Z", 64'(zf[0]), 64'd0);
        cmp("rst_valid_s8", 64'(vo[2]), 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        step;
        cmp("ready_after_rst", 64'({ir[0], ir[1], ir[2]}), 64'b111);

        // Pin the model with hand-worked values.
        m = model(24, 64'h5, 64'h7, 1'b1);
        cmp("model_sub_S", 64'(m.s), 64'hFFFFFE);
        cmp("model_sub_Co", 64'(m.co), 64'd0);
        m = model(24, 64'h800000, 64'h1, 1'b1);
        cmp("model_ov", 64'({m.s, m.ov, m.co}), {32'h7FFFFF, 2'b11});
        m = model(8, 64'hFF, 64'h1, 1'b0);
        cmp("model_w8", 64'({m.s, m.co, m.z}), {32'h0, 2'b11});

        // Directed cases.
        directed(24'h000001, 24'h000001, 1'b0, 24'h000002, 1'b0, 1'b0, 1'b0);
        directed(24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1);
        cmp("s8_ff_plus_1", 64'({l8s, l8co, l8z}), {8'h00, 2'b11});
        directed(24'h000005, 24'h000007, 1'b1, 24'hFFFFFE, 1'b0, 1'b0, 1'b0);
        directed(24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1, 1'b0);
        directed(24'h800000, 24'h000001, 1'b1, 24'h7FFFFF, 1'b1, 1'b1, 1'b0);

        // Back-to-back stream of 10 ops with the consumer stalled on cycles 4-6.
        n = 0; cyc = 0;
        A = 24'($urandom()); B = 24'($urandom()); aos = 1'($urandom());
        in_valid = 1'b1;
        while (n < 10 && cyc < 60) begin
            cyc++;
            out_ready = !(cyc >= 4 && cyc <= 6);
            @(negedge clk);
            acc = ir[0];
            if (cyc == 5) cmp("stall_in_ready", 64'(ir[0]), 64'd0);
            step;
            if (acc) begin
                n++;
                A = 24'($urandom()); B = 24'($urandom()); aos = 1'($urandom());
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cmp("stream_cycles", 64'(cyc), 64'd13);
        drain;

        // Asynchronous reset with three ops in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            A = 24'($urandom()); B = 24'($urandom()); aos = 1'($urandom());
            step;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        cmp("arst_outputs", 64'({vo[0], s3, co[0], ovf[0], zf[0]}), 64'd0);
        cmp("arst_valid_others", 64'({vo[1], vo[2]}), 64'd0);
        out_ready = 1'b1;
        step;
        step;
        rst = 1'b0;
        step;
        cmp("ready_after_arst", 64'(ir[0]), 64'd1);
        directed(24'h123456, 24'h0FEDCB, 1'b0, 24'h222221, 1'b0, 1'b0, 1'b0);

        // Random traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            A = 24'($urandom()); B = 24'($urandom()); aos = 1'($urandom());
            if ($urandom_range(0, 7) == 0) A = 24'hFFFFFF;
            if ($urandom_range(0, 7) == 0) B = A;
            step;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
